ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute-to-memory pipeline stage of the MIPS processor. It sits directly downstream of the ALU and captures the ALU result and zero flag with the operation's control bits. It resolves conditional branches (BEQ) and computes the branch target. Results are buffered in a 2-entry valid/ready FIFO, so a stalled memory stage never drops an ALU result and `in_ready` never depends combinationally on `out_ready`.

## Interface
- No parameters; all widths are fixed: 32-bit data, 5-bit register index.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  EX presents an operation this cycle.
- `in_ready`  out  1  stage can accept; registered, equals (count < 2).
- `alu_out`  in  32  ALU result.
- `alu_zero`  in  1  ALU zero flag (meaningful for sub).
- `rt_data`  in  32  store data.
- `write_reg`  in  5  destination register index.
- `pc_plus4`  in  32  PC+4 of the operation.
- `imm_ext`  in  32  sign-extended immediate.
- `branch, mem_read, mem_write, reg_write, mem_to_reg`  in  1 each  control bits.
- `flush`  in  1  kill all buffered and incoming entries.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  MEM consumes head.
- `out_alu`, `out_rt_data`  out  32 each  head fields.
- `out_write_reg`  out  5  head field.
- `out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg`  out  1 each  head fields.
- `redirect`  out  1  one-cycle pulse: taken branch accepted.
- `redirect_pc`  out  32  target; valid when `redirect`=1.

## Operation
- Storage: 2 entries, head pointer `rd_ptr` (1 bit), `wr_ptr` (1 bit), `count` (0..2).
- Push: `in_valid & in_ready & ~flush`. Writes the entry at `wr_ptr`, then `wr_ptr` toggles.
- Pop: `out_valid & out_ready & ~flush`. `rd_ptr` toggles.
- Count update: push only → +1; pop only → −1; both → unchanged.
- `out_valid` = (count != 0). Head fields are driven from `mem[rd_ptr]`. When count = 0, all head fields read 0.
- Branch resolution on push:
  - taken = `branch & alu_zero`.
  - target = `pc_plus4 + (imm_ext << 2)`, truncated to 32 bits (wrap-around is ignored).
  - If taken: next cycle `redirect`=1 and `redirect_pc`=target. Otherwise `redirect`=0 and `redirect_pc` holds its last value.
- Branch entries still enter the FIFO with `reg_write=mem_read=mem_write=0`. Control bits are forced to 0 on push when `branch`=1.
- Flush:
  - On the next edge, count=0 and both pointers=0.
  - The incoming operation is discarded and no `redirect` is generated.
  - Flush overrides simultaneous push and pop.
- Full (count=2): `in_ready`=0, and `in_valid` is ignored.
- Empty: `out_ready` is ignored.
- Entries are never reordered and never overwritten while valid.

## Timing
- Reset (async, `rst_n`=0):
  - count=0, pointers=0, `in_ready`=1, `out_valid`=0.
  - All out_* fields=0, `redirect`=0, `redirect_pc`=0.
- Reset mid-operation drops all entries immediately, with no pending `redirect`.
- Latency: an operation accepted at edge N appears on `out_valid` after edge N, if the FIFO was empty. `redirect` asserts for exactly the cycle after edge N.
- Throughput: 1 op/cycle sustained when `out_ready`=1 (count stays ≤1).
- `in_ready` is a registered function of count only. Upstream must hold `in_valid` and data until accepted.
- `out_valid` and head data are stable until popped or flushed.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `in_ready`=1, `out_valid`=0, `redirect`=0, all outputs 0; release, push `alu_out`=0x0000_0005, `reg_write`=1 → next cycle `out_alu`=5, `out_reg_write`=1.
- Backpressure: `out_ready`=0, push A=0x11, B=0x22 → `in_ready`=0 after the second edge; C=0x33 held with `in_valid`=1 is not lost. Raise `out_ready` → outputs 0x11, 0x22, 0x33 in order, one per cycle.
- Simultaneous push/pop at count=1 → count stays 1, `in_ready` stays 1, no bubble across 10 back-to-back ops 0..9.
- Branch: `branch`=1, `alu_zero`=1, `pc_plus4`=0x0000_0040, `imm_ext`=0xFFFF_FFFC → one-cycle `redirect`, `redirect_pc`=0x0000_0030, entry control bits 0. Same with `alu_zero`=0 → no `redirect`.
- Target wrap: `pc_plus4`=0xFFFF_FFFC, `imm_ext`=1 → `redirect_pc`=0x0000_0000.
- Flush: count=2 plus `in_valid` and `flush` in the same cycle, with a taken branch incoming → next cycle `out_valid`=0, `in_ready`=1, `redirect`=0. The next push appears alone at the head.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: captures ALU results in a 2-entry valid/ready FIFO and
// resolves BEQ branches on acceptance, pulsing a redirect to the fetch stage.
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic [31:0] rt_data,
    input  logic [4:0]  write_reg,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] imm_ext,
    input  logic        branch,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_alu,
    output logic [31:0] out_rt_data,
    output logic [4:0]  out_write_reg,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_reg_write,
    output logic        out_mem_to_reg,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rt_data;
        logic [4:0]  write_reg;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
    } entry_t;

    entry_t      mem_q [2];
    entry_t      mem_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        in_ready_q, in_ready_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        push, pop, taken;
    logic [31:0] target;
    entry_t      in_entry;
    entry_t      head;

    always_comb begin
        push   = in_valid & in_ready_q & ~flush;
        pop    = (count_q != 2'd0) & out_ready & ~flush;
        taken  = branch & alu_zero;
        target = pc_plus4 + (imm_ext << 2);

        // Branches still occupy a slot but must not touch memory or the register file.
        in_entry.alu        = alu_out;
        in_entry.rt_data    = rt_data;
        in_entry.write_reg  = write_reg;
        in_entry.mem_read   = mem_read   & ~branch;
        in_entry.mem_write  = mem_write  & ~branch;
        in_entry.reg_write  = reg_write  & ~branch;
        in_entry.mem_to_reg = mem_to_reg & ~branch;

        mem_d         = mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = ~wr_ptr_q;
            if (taken) begin
                redirect_d    = 1'b1;
                redirect_pc_d = target;
            end
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end

        in_ready_d = (count_d < 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]      <= '0;
            mem_q[1]      <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            in_ready_q    <= 1'b1;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            mem_q         <= mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        head = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = (count_q != 2'd0);
    assign out_alu        = head.alu;
    assign out_rt_data    = head.rt_data;
    assign out_write_reg  = head.write_reg;
    assign out_mem_read   = head.mem_read;
    assign out_mem_write  = head.mem_write;
    assign out_reg_write  = head.reg_write;
    assign out_mem_to_reg = head.mem_to_reg;
    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed pushes queue expected head entries
// and redirect targets; a negedge monitor compares them as the DUT presents them.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] alu_out, rt_data, pc_plus4, imm_ext;
    logic        alu_zero;
    logic [4:0]  write_reg;
    logic        branch, mem_read, mem_write, reg_write, mem_to_reg;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_alu, out_rt_data;
    logic [4:0]  out_write_reg;
    logic        out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    logic [72:0] exp_q [$];
    logic [31:0] redir_q [$];

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_zero(alu_zero), .rt_data(rt_data),
        .write_reg(write_reg), .pc_plus4(pc_plus4), .imm_ext(imm_ext),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu(out_alu), .out_rt_data(out_rt_data), .out_write_reg(out_write_reg),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [72:0] head_vec();
        return {out_alu, out_rt_data, out_write_reg,
                out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg};
    endfunction

    // Monitor: compare head on every handshake and every redirect pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (redirect) begin
                    if (redir_q.size() == 0) chk("unexpected_redirect", 96'd1, 96'd0);
                    else chk("redirect_pc", redirect_pc, redir_q.pop_front());
                end
                if (!flush && out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_head", head_vec(), 96'd0);
                    else chk("head_entry", head_vec(), exp_q.pop_front());
                end
            end
        end
    end

    task automatic idle();
        in_valid = 1'b0; branch = 1'b0; alu_zero = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
        alu_out = '0; rt_data = '0; write_reg = '0; pc_plus4 = '0; imm_ext = '0;
    endtask

    // Drive one op and hold it until accepted; ctl = {mem_read, mem_write, reg_write, mem_to_reg}.
    task automatic push_op(input logic [31:0] a, input logic [31:0] rt, input logic [4:0] wr,
                           input logic [3:0] ctl, input logic br, input logic z,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] exp_tgt);
        logic acc;
        int   n;
        in_valid = 1'b1; alu_out = a; rt_data = rt; write_reg = wr;
        {mem_read, mem_write, reg_write, mem_to_reg} = ctl;
        branch = br; alu_zero = z; pc_plus4 = pc; imm_ext = imm;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end
        if (!acc) begin
            chk("accept_timeout", 96'd0, 96'd1);
        end else begin
            exp_q.push_back({a, rt, wr, br ? 4'b0000 : ctl});
            if (br && z) redir_q.push_back(exp_tgt);
        end
        #1;
        if (acc) chk("redirect_pulse", {95'd0, redirect}, {95'd0, br & z});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_q.size(), 96'd0);
    endtask

    initial begin
        idle();
        flush = 1'b0; out_ready = 1'b0; rst_n = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom); alu_out = $urandom; rt_data = $urandom;
            branch = 1'($urandom); alu_zero = 1'($urandom); out_ready = 1'($urandom);
            reg_write = 1'($urandom); pc_plus4 = $urandom; imm_ext = $urandom;
            @(negedge clk);
        end
        chk("rst_in_ready", {95'd0, in_ready}, {95'd0, 1'b1});
        chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
        chk("rst_redirect", {redirect_pc, redirect}, 96'd0);
        chk("rst_head", head_vec(), 96'd0);
        idle();
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First op after reset
        push_op(32'h5, 32'h0, 5'd3, 4'b0010, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("latency_out_valid", {95'd0, out_valid}, {95'd0, 1'b1});
        idle();
        drain();

        // Backpressure: A, B fill the FIFO, C waits
        out_ready = 1'b0;
        push_op(32'h11, 32'hA1, 5'd1, 4'b1011, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        push_op(32'h22, 32'hB2, 5'd2, 4'b0100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("full_in_ready", {95'd0, in_ready}, 96'd0);
        fork
            push_op(32'h33, 32'hC3, 5'd4, 4'b0010, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
            begin
                repeat (3) @(posedge clk);
                #1 chk("held_head", out_alu, 96'h11);
                out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Sustained throughput: 10 back-to-back ops
        for (int i = 0; i < 10; i++) begin
            push_op(i, ~i, 5'(i), 4'b0010, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
            chk("stream_in_ready", {95'd0, in_ready}, {95'd0, 1'b1});
        end
        idle();
        drain();

        // Taken branch: 0x40 + (-4 << 2) = 0x30, control bits forced low
        push_op(32'h0, 32'h7, 5'd9, 4'b1110, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFC, 32'h30);
        idle();
        @(posedge clk); #1;
        chk("redirect_one_cycle", {95'd0, redirect}, 96'd0);
        chk("redirect_pc_hold", redirect_pc, 96'h30);
        // Not taken
        push_op(32'h1, 32'h7, 5'd9, 4'b1110, 1'b1, 1'b0, 32'h40, 32'hFFFF_FFFC, 32'h0);
        chk("not_taken_pc_hold", redirect_pc, 96'h30);
        // Target wrap: 0xFFFF_FFFC + 4 = 0
        push_op(32'h0, 32'h0, 5'd0, 4'b0000, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1, 32'h0);
        idle();
        drain();

        // Flush with full FIFO and a taken branch incoming
        out_ready = 1'b0;
        push_op(32'hAA, 32'h0, 5'd5, 4'b0010, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        push_op(32'hBB, 32'h0, 5'd6, 4'b0010, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        in_valid = 1'b1; branch = 1'b1; alu_zero = 1'b1; pc_plus4 = 32'h100; imm_ext = 32'h4;
        flush = 1'b1; out_ready = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        chk("flush_out_valid", {95'd0, out_valid}, 96'd0);
        chk("flush_in_ready", {95'd0, in_ready}, {95'd0, 1'b1});
        chk("flush_redirect", {95'd0, redirect}, 96'd0);
        push_op(32'hCC, 32'h0, 5'd7, 4'b0001, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        idle();
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("redirect_queue_empty", redir_q.size(), 96'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
